// File: rtl/m107_int_sequencer.sv
// Interrupt sequencer between the M107 PIC and the V33 core: CPU request, two-pulse INTA, vector handoff.
// Optional statistics counters are enabled by defining M107_INTSEQ_STATS_EN.
module m107_int_sequencer #(
    parameter int unsigned ACK_HIGH        = 2,
    parameter int unsigned ACK_GAP         = 2,
    parameter logic [7:0]  SPURIOUS_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        pic_int_req,
    input  logic [7:0]  pic_int_vector,
    output logic        pic_int_ack,
    input  logic        cpu_irq_en,
    output logic        cpu_int_req,
    input  logic        cpu_int_ack,
    output logic [7:0]  cpu_vector,
    output logic        cpu_vector_valid,
    input  logic        cpu_vector_taken,
    output logic        busy
`ifdef M107_INTSEQ_STATS_EN
    ,
    output logic [15:0] stat_taken,
    output logic [15:0] stat_spurious,
    input  logic        stat_clear
`endif
);

    localparam logic [3:0] ACK_HIGH_C = 4'(ACK_HIGH);
    localparam logic [3:0] ACK_GAP_C  = 4'(ACK_GAP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_ACK1_HI = 3'd2,
        ST_ACK1_LO = 3'd3,
        ST_ACK2_HI = 3'd4,
        ST_ACK2_LO = 3'd5,
        ST_DELIVER = 3'd6
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [7:0] vector_r, vector_s;
    logic       pic_ack_r, cpu_req_r, valid_r, busy_r;
    logic       real_dlv_s, spur_dlv_s;

    // Next-state, counter reload and vector capture
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        vector_s   = vector_r;
        real_dlv_s = 1'b0;
        spur_dlv_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pic_int_req && cpu_irq_en) begin
                    state_s = ST_REQ;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Acknowledge takes precedence over a request dropping in the same cycle
                if (cpu_int_ack) begin
                    state_s = ST_ACK1_HI;
                    cnt_s   = ACK_HIGH_C;
                end else if (!pic_int_req || !cpu_irq_en) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACK1_HI: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_ACK1_LO;
                    cnt_s   = ACK_GAP_C;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK1_LO: begin
                if (cnt_r <= 4'd1) begin
                    if (!pic_int_req) begin
                        state_s    = ST_DELIVER;
                        cnt_s      = 4'd0;
                        vector_s   = SPURIOUS_VECTOR;
                        spur_dlv_s = 1'b1;
                    end else begin
                        state_s  = ST_ACK2_HI;
                        cnt_s    = ACK_HIGH_C;
                        vector_s = pic_int_vector;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK2_HI: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_ACK2_LO;
                    cnt_s   = 4'd1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK2_LO: begin
                if (cnt_r <= 4'd1) begin
                    state_s    = ST_DELIVER;
                    cnt_s      = 4'd0;
                    real_dlv_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DELIVER: begin
                if (cpu_vector_taken) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_DELIVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            vector_r  <= 8'h00;
            pic_ack_r <= 1'b0;
            cpu_req_r <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else if (ce) begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            vector_r  <= vector_s;
            pic_ack_r <= (state_s == ST_ACK1_HI) || (state_s == ST_ACK2_HI);
            cpu_req_r <= (state_s == ST_REQ);
            valid_r   <= (state_s == ST_DELIVER);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign pic_int_ack      = pic_ack_r;
    assign cpu_int_req      = cpu_req_r;
    assign cpu_vector       = vector_r;
    assign cpu_vector_valid = valid_r;
    assign busy             = busy_r;

`ifdef M107_INTSEQ_STATS_EN
    logic [15:0] stat_taken_r, stat_spurious_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Delivery statistics; clear has priority over increment
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_taken_r    <= 16'h0000;
            stat_spurious_r <= 16'h0000;
        end else if (ce) begin
            if (stat_clear) begin
                stat_taken_r    <= 16'h0000;
                stat_spurious_r <= 16'h0000;
            end else begin
                if (real_dlv_s) stat_taken_r <= sat_inc(stat_taken_r);
                if (spur_dlv_s) stat_spurious_r <= sat_inc(stat_spurious_r);
            end
        end
    end

    assign stat_taken    = stat_taken_r;
    assign stat_spurious = stat_spurious_r;
`else
    logic unused_dlv_s;
    assign unused_dlv_s = real_dlv_s ^ spur_dlv_s;
`endif

endmodule

// File: doc/m107_int_sequencer.md
Name: m107_int_sequencer

Overview:
- Sits between the M107 programmable interrupt controller and the V33 CPU core.
- Converts the PIC's level int_req into a CPU interrupt request.
- On CPU acknowledge, runs the two-pulse INTA sequence on the PIC, captures the vector and delivers it to the CPU with a valid/taken handshake.
- Handles withdrawn (masked) requests and spurious interrupts deterministically.

Parameters:
ACK_HIGH, 2, ce-cycles each pic_int_ack pulse is held high (1..15)
ACK_GAP, 2, ce-cycles pic_int_ack is low between pulse 1 and pulse 2 (1..15)
SPURIOUS_VECTOR, 8'hFF, vector delivered when the request vanishes mid-sequence

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset, sampled on rising clk regardless of ce
ce  in  1  clock enable; all timing counts ce-qualified cycles, state holds when low
pic_int_req  in  1  PIC has an unmasked pending interrupt
pic_int_vector  in  8  vector driven by PIC, valid after first ack rising edge
pic_int_ack  out  1  INTA strobe to PIC (two pulses per interrupt)
cpu_irq_en  in  1  CPU interrupt-enable flag (IE)
cpu_int_req  out  1  interrupt request to CPU
cpu_int_ack  in  1  one-ce-cycle pulse: CPU has begun its INTA cycle
cpu_vector  out  8  vector for CPU
cpu_vector_valid  out  1  cpu_vector is valid
cpu_vector_taken  in  1  CPU consumed vector
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 (cpu_vector=8'h00); counters 0. Reset mid-sequence aborts immediately with no completion. The PIC shares the same reset.
- All registers update only on clk edges with ce=1. All outputs are registered.
- IDLE: if pic_int_req & cpu_irq_en -> REQ; set cpu_int_req=1. At least one ce-cycle is always spent in IDLE after DELIVER.
- REQ, evaluated in priority order:
  - cpu_int_ack=1 -> ACK1_HI; cpu_int_req=0; load counter. Acknowledge wins over a simultaneous request drop.
  - else ~pic_int_req | ~cpu_irq_en -> IDLE; cpu_int_req=0 (request withdrawn).
- ACK1_HI: pic_int_ack=1 for exactly ACK_HIGH ce-cycles -> ACK1_LO.
- ACK1_LO: pic_int_ack=0 for ACK_GAP ce-cycles. On the last gap cycle:
  - pic_int_req=0 -> latch cpu_vector=SPURIOUS_VECTOR, skip pulse 2, go to DELIVER.
  - else latch cpu_vector=pic_int_vector -> ACK2_HI.
- ACK2_HI: pic_int_ack=1 for ACK_HIGH ce-cycles -> ACK2_LO.
- ACK2_LO: pic_int_ack=0 for 1 ce-cycle (PIC clears IRR bit) -> DELIVER.
- DELIVER: cpu_vector_valid=1, cpu_vector stable.
  - cpu_vector_taken=1 -> IDLE; valid=0 the next ce-cycle.
  - cpu_int_ack while in DELIVER or ACK states is ignored.
- pic_int_ack rising edge count per delivered vector:
  - exactly 2 for a normal interrupt;
  - exactly 1 for a spurious one.
- pic_int_ack never goes high outside the ACK*_HI states.
- cpu_int_req is high only in REQ.
- Counter: 4-bit down-counter, reloaded on every state entry; transition fires when it reaches 1.
- ce low at any point: everything freezes, pulse widths are preserved in ce-cycles.

Optional Feature:
- Macro M107_INTSEQ_STATS_EN.
- Defined: adds outputs stat_taken[15:0] and stat_spurious[15:0], plus input stat_clear.
  - stat_taken increments on each DELIVER entry with a real vector.
  - stat_spurious increments on each spurious DELIVER.
  - Both counters saturate at 16'hFFFF and clear on reset or stat_clear (clear wins over increment).
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Basic: PIC model IW2 base 8'h20, raise IR2, cpu_irq_en=1; pulse cpu_int_ack -> cpu_int_req rises 1 ce-cycle after the request. With defaults, pic_int_ack pattern from the cycle after the ack is 1,1,0,0,1,1,0. Then cpu_vector=8'h22 with valid=1; taken -> IDLE; PIC IR2 cleared.
- Withdraw: request raised, cpu_int_req=1; mask IR2 (pic_int_req=0) before ack -> cpu_int_req falls next ce-cycle, pic_int_ack never pulses, busy=0.
- Spurious: after ACK1_HI, force pic_int_req=0 during the gap -> single ack pulse; cpu_vector=8'hFF, valid=1; stat_spurious=1 if enabled.
- IE gating/priority: cpu_irq_en=0 with IR0 and IR5 pending -> no cpu_int_req. Set IE=1 and complete the sequence -> vector 8'h20. Next sequence -> 8'h25, after at least one IDLE cycle.
- ce stretch: ce high every 3rd clk during the sequence -> each ack pulse spans ACK_HIGH ce-cycles (6 clks); vector correct.
- Reset mid-op: assert reset during ACK2_HI -> next clk pic_int_ack=0, valid=0, cpu_int_req=0, busy=0; stats cleared.
